// File: rtl/stg_ma_if.sv
// Data-memory port of the memory-access stage: one req/ack transaction at a time.
`ifndef STG_MA_DEFS
`define STG_MA_DEFS
`define HBIT_ADDR   47
`define HBIT_DATA   23
`define HBIT_OPC    7
`define HBIT_TGT_GP 3
`define HBIT_TGT_SR 1
`define HBIT_TGT_AR 1
`define OPC_NOP     8'h00
`define OPC_ADD     8'h01
`define OPC_LDu     8'h30
`define OPC_LDs     8'h31
`define OPC_LDso    8'h32
`define OPC_STu     8'h38
`define OPC_STs     8'h39
`define OPC_STso    8'h3A
`endif

interface stg_ma_if;
  logic                ow_mem_req;
  logic                ow_mem_we;
  logic [`HBIT_ADDR:0] ow_mem_addr;
  logic [`HBIT_DATA:0] ow_mem_wdata;
  logic                iw_mem_ack;
  logic [`HBIT_DATA:0] iw_mem_rdata;

  modport master (
    output ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    input  iw_mem_ack, iw_mem_rdata
  );

  modport slave (
    input  ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    output iw_mem_ack, iw_mem_rdata
  );
endinterface

// File: rtl/stg_ma.sv
// Memory-access stage: registers EX results, runs load/store transactions
// on the data-memory port with a wait-cycle timeout, stalls IF..EX meanwhile.
//
// state  | meaning
// S_IDLE | pass-through; a memory opcode launches a transaction
// S_WAIT | request outstanding, bubbles out, stall raised upstream
`ifndef STG_MA_DEFS
`define STG_MA_DEFS
`define HBIT_ADDR   47
`define HBIT_DATA   23
`define HBIT_OPC    7
`define HBIT_TGT_GP 3
`define HBIT_TGT_SR 1
`define HBIT_TGT_AR 1
`define OPC_NOP     8'h00
`define OPC_ADD     8'h01
`define OPC_LDu     8'h30
`define OPC_LDs     8'h31
`define OPC_LDso    8'h32
`define OPC_STu     8'h38
`define OPC_STs     8'h39
`define OPC_STso    8'h3A
`endif

module stg_ma #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic [`HBIT_ADDR:0]   iw_pc,
  output logic [`HBIT_ADDR:0]   ow_pc,
  input  logic [`HBIT_DATA:0]   iw_instr,
  output logic [`HBIT_DATA:0]   ow_instr,
  input  logic [`HBIT_OPC:0]    iw_opc,
  output logic [`HBIT_OPC:0]    ow_opc,
  input  logic [`HBIT_TGT_GP:0] iw_tgt_gp,
  output logic [`HBIT_TGT_GP:0] ow_tgt_gp,
  input  logic                  iw_tgt_gp_we,
  output logic                  ow_tgt_gp_we,
  input  logic [`HBIT_TGT_SR:0] iw_tgt_sr,
  output logic [`HBIT_TGT_SR:0] ow_tgt_sr,
  input  logic                  iw_tgt_sr_we,
  output logic                  ow_tgt_sr_we,
  input  logic [`HBIT_TGT_AR:0] iw_tgt_ar,
  output logic [`HBIT_TGT_AR:0] ow_tgt_ar,
  input  logic                  iw_tgt_ar_we,
  output logic                  ow_tgt_ar_we,
  input  logic [`HBIT_ADDR:0]   iw_addr,
  input  logic [`HBIT_DATA:0]   iw_result,
  output logic [`HBIT_DATA:0]   ow_result,
  input  logic [`HBIT_ADDR:0]   iw_ar_result,
  output logic [`HBIT_ADDR:0]   ow_ar_result,
  input  logic [`HBIT_ADDR:0]   iw_sr_result,
  output logic [`HBIT_ADDR:0]   ow_sr_result,
  stg_ma_if.master              mem,
  output logic                  ow_stall_req,
  output logic                  ow_mem_fault,
  input  logic                  iw_flush,
  input  logic                  iw_stall
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [`HBIT_ADDR:0]   pc;
    logic [`HBIT_DATA:0]   instr;
    logic [`HBIT_OPC:0]    opc;
    logic [`HBIT_TGT_GP:0] tgt_gp;
    logic                  tgt_gp_we;
    logic [`HBIT_TGT_SR:0] tgt_sr;
    logic                  tgt_sr_we;
    logic [`HBIT_TGT_AR:0] tgt_ar;
    logic                  tgt_ar_we;
    logic [`HBIT_DATA:0]   result;
    logic [`HBIT_ADDR:0]   ar_result;
    logic [`HBIT_ADDR:0]   sr_result;
  } wb_t;

  function automatic logic is_load(input logic [`HBIT_OPC:0] opc);
    return (opc == `OPC_LDu) || (opc == `OPC_LDs) || (opc == `OPC_LDso);
  endfunction

  function automatic logic is_store(input logic [`HBIT_OPC:0] opc);
    return (opc == `OPC_STu) || (opc == `OPC_STs) || (opc == `OPC_STso);
  endfunction

  state_t              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                flush_seen_q, flush_seen_d;
  logic                fault_q, fault_d;
  wb_t                 wb_q, wb_d;
  wb_t                 hold_q, hold_d;
  wb_t                 wb_in;
  logic                mem_we_q, mem_we_d;
  logic [`HBIT_ADDR:0] mem_addr_q, mem_addr_d;
  logic [`HBIT_DATA:0] mem_wdata_q, mem_wdata_d;

  // Bundle the incoming EX fields so capture and pass-through share one path.
  always_comb begin
    wb_in           = '0;
    wb_in.pc        = iw_pc;
    wb_in.instr     = iw_instr;
    wb_in.opc       = iw_opc;
    wb_in.tgt_gp    = iw_tgt_gp;
    wb_in.tgt_gp_we = iw_tgt_gp_we;
    wb_in.tgt_sr    = iw_tgt_sr;
    wb_in.tgt_sr_we = iw_tgt_sr_we;
    wb_in.tgt_ar    = iw_tgt_ar;
    wb_in.tgt_ar_we = iw_tgt_ar_we;
    wb_in.result    = iw_result;
    wb_in.ar_result = iw_ar_result;
    wb_in.sr_result = iw_sr_result;
  end

  // Next-state, transaction and write-back field selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_seen_d = flush_seen_q;
    fault_d      = 1'b0;
    wb_d         = wb_q;
    hold_d       = hold_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (!iw_stall) begin
          if (iw_flush) begin
            wb_d = '0;
          end else if (is_load(iw_opc) || is_store(iw_opc)) begin
            hold_d       = wb_in;
            wb_d         = '0;
            mem_addr_d   = iw_addr;
            mem_we_d     = is_store(iw_opc);
            mem_wdata_d  = is_store(iw_opc) ? iw_result : '0;
            cnt_d        = '0;
            flush_seen_d = 1'b0;
            state_d      = S_WAIT;
          end else begin
            wb_d = wb_in;
          end
        end
      end

      S_WAIT: begin
        if (iw_flush) flush_seen_d = 1'b1;
        if (mem.iw_mem_ack) begin
          wb_d = hold_q;
          if (!is_store(hold_q.opc)) wb_d.result = mem.iw_mem_rdata;
          // Stores never write a register; a flushed load still completes on
          // the bus but its data must not retire.
          if (is_store(hold_q.opc) || flush_seen_q || iw_flush) begin
            wb_d.tgt_gp_we = 1'b0;
            wb_d.tgt_sr_we = 1'b0;
            wb_d.tgt_ar_we = 1'b0;
          end
          flush_seen_d = 1'b0;
          state_d      = S_IDLE;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          wb_d         = '0;
          fault_d      = 1'b1;
          flush_seen_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flush_seen_q <= 1'b0;
      fault_q      <= 1'b0;
      wb_q         <= '0;
      hold_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_seen_q <= flush_seen_d;
      fault_q      <= fault_d;
      wb_q         <= wb_d;
      hold_q       <= hold_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Request and stall are exactly "transaction outstanding".
  assign mem.ow_mem_req   = (state_q == S_WAIT);
  assign mem.ow_mem_we    = mem_we_q;
  assign mem.ow_mem_addr  = mem_addr_q;
  assign mem.ow_mem_wdata = mem_wdata_q;
  assign ow_stall_req     = (state_q == S_WAIT);
  assign ow_mem_fault     = fault_q;

  assign ow_pc        = wb_q.pc;
  assign ow_instr     = wb_q.instr;
  assign ow_opc       = wb_q.opc;
  assign ow_tgt_gp    = wb_q.tgt_gp;
  assign ow_tgt_gp_we = wb_q.tgt_gp_we;
  assign ow_tgt_sr    = wb_q.tgt_sr;
  assign ow_tgt_sr_we = wb_q.tgt_sr_we;
  assign ow_tgt_ar    = wb_q.tgt_ar;
  assign ow_tgt_ar_we = wb_q.tgt_ar_we;
  assign ow_result    = wb_q.result;
  assign ow_ar_result = wb_q.ar_result;
  assign ow_sr_result = wb_q.sr_result;

endmodule

// File: tb/tb_stg_ma.sv
// Self-checking bench for stg_ma: scoreboarded write-back results plus
// direct checks of the memory handshake, stall, fault and reset behaviour.
`ifndef STG_MA_DEFS
`define STG_MA_DEFS
`define HBIT_ADDR   47
`define HBIT_DATA   23
`define HBIT_OPC    7
`define HBIT_TGT_GP 3
`define HBIT_TGT_SR 1
`define HBIT_TGT_AR 1
`define OPC_NOP     8'h00
`define OPC_ADD     8'h01
`define OPC_LDu     8'h30
`define OPC_LDs     8'h31
`define OPC_LDso    8'h32
`define OPC_STu     8'h38
`define OPC_STs     8'h39
`define OPC_STso    8'h3A
`endif

module tb_stg_ma;
  localparam int TIMEOUT = 16;

  logic                  iw_clk = 1'b0;
  logic                  iw_rst;
  logic [`HBIT_ADDR:0]   iw_pc, ow_pc;
  logic [`HBIT_DATA:0]   iw_instr, ow_instr;
  logic [`HBIT_OPC:0]    iw_opc, ow_opc;
  logic [`HBIT_TGT_GP:0] iw_tgt_gp, ow_tgt_gp;
  logic                  iw_tgt_gp_we, ow_tgt_gp_we;
  logic [`HBIT_TGT_SR:0] iw_tgt_sr, ow_tgt_sr;
  logic                  iw_tgt_sr_we, ow_tgt_sr_we;
  logic [`HBIT_TGT_AR:0] iw_tgt_ar, ow_tgt_ar;
  logic                  iw_tgt_ar_we, ow_tgt_ar_we;
  logic [`HBIT_ADDR:0]   iw_addr;
  logic [`HBIT_DATA:0]   iw_result, ow_result;
  logic [`HBIT_ADDR:0]   iw_ar_result, ow_ar_result;
  logic [`HBIT_ADDR:0]   iw_sr_result, ow_sr_result;
  logic                  ow_stall_req, ow_mem_fault;
  logic                  iw_flush, iw_stall;

  stg_ma_if mem_if ();

  stg_ma #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst),
    .iw_pc(iw_pc), .ow_pc(ow_pc),
    .iw_instr(iw_instr), .ow_instr(ow_instr),
    .iw_opc(iw_opc), .ow_opc(ow_opc),
    .iw_tgt_gp(iw_tgt_gp), .ow_tgt_gp(ow_tgt_gp),
    .iw_tgt_gp_we(iw_tgt_gp_we), .ow_tgt_gp_we(ow_tgt_gp_we),
    .iw_tgt_sr(iw_tgt_sr), .ow_tgt_sr(ow_tgt_sr),
    .iw_tgt_sr_we(iw_tgt_sr_we), .ow_tgt_sr_we(ow_tgt_sr_we),
    .iw_tgt_ar(iw_tgt_ar), .ow_tgt_ar(ow_tgt_ar),
    .iw_tgt_ar_we(iw_tgt_ar_we), .ow_tgt_ar_we(ow_tgt_ar_we),
    .iw_addr(iw_addr),
    .iw_result(iw_result), .ow_result(ow_result),
    .iw_ar_result(iw_ar_result), .ow_ar_result(ow_ar_result),
    .iw_sr_result(iw_sr_result), .ow_sr_result(ow_sr_result),
    .mem(mem_if),
    .ow_stall_req(ow_stall_req), .ow_mem_fault(ow_mem_fault),
    .iw_flush(iw_flush), .iw_stall(iw_stall)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct {
    string               tag;
    logic [`HBIT_DATA:0] result;
    logic                chk_res;
    logic                gp_we;
    logic                fault;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [`HBIT_ADDR:0] pc_ctr = 48'h1000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic drive_op(input logic [`HBIT_OPC:0] opc, input logic [`HBIT_ADDR:0] addr,
                          input logic [`HBIT_DATA:0] res, input logic [`HBIT_TGT_GP:0] gp,
                          input logic gp_we);
    pc_ctr       = pc_ctr + 48'd4;
    iw_pc        = pc_ctr;
    iw_instr     = {16'hC0DE, opc};
    iw_opc       = opc;
    iw_tgt_gp    = gp;
    iw_tgt_gp_we = gp_we;
    iw_tgt_sr    = '0;
    iw_tgt_sr_we = 1'b0;
    iw_tgt_ar    = '0;
    iw_tgt_ar_we = 1'b0;
    iw_addr      = addr;
    iw_result    = res;
    iw_ar_result = 48'h0;
    iw_sr_result = 48'h0;
  endtask

  task automatic drive_nop();
    drive_op(`OPC_NOP, '0, '0, '0, 1'b0);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      if (e.chk_res) chk({e.tag, "_result"}, 64'(ow_result), 64'(e.result));
      chk({e.tag, "_gp_we"}, 64'(ow_tgt_gp_we), 64'(e.gp_we));
      chk({e.tag, "_fault"}, 64'(ow_mem_fault), 64'(e.fault));
    end
  endtask

  // Non-memory op: one-cycle latency, optionally with a stray ack on the bus.
  task automatic alu(input string tag, input logic [`HBIT_DATA:0] res,
                     input logic [`HBIT_TGT_GP:0] gp, input logic stray_ack);
    logic [`HBIT_ADDR:0] pc_exp;
    drive_op(`OPC_ADD, 48'h0, res, gp, 1'b1);
    pc_exp = iw_pc;
    mem_if.iw_mem_ack = stray_ack;
    sb.push_back('{tag: tag, result: res, chk_res: 1'b1, gp_we: 1'b1, fault: 1'b0});
    step();
    mem_if.iw_mem_ack = 1'b0;
    drive_nop();
    pop_check();
    chk({tag, "_gp"}, 64'(ow_tgt_gp), 64'(gp));
    chk({tag, "_pc"}, 64'(ow_pc), 64'(pc_exp));
    chk({tag, "_req"}, 64'(mem_if.ow_mem_req), 64'd0);
  endtask

  // Memory op: ack_at = req cycle carrying the ack (0 = never), flush_at =
  // req cycle carrying a flush (0 = none).
  task automatic mem_op(input string tag, input logic [`HBIT_OPC:0] opc,
                        input logic [`HBIT_ADDR:0] addr, input logic [`HBIT_DATA:0] data,
                        input logic [`HBIT_TGT_GP:0] gp, input int ack_at,
                        input logic [`HBIT_DATA:0] rdata, input int flush_at,
                        input int exp_cycles);
    logic is_st;
    int   reqc;
    logic done;
    exp_t e;
    is_st = (opc == `OPC_STu) || (opc == `OPC_STs) || (opc == `OPC_STso);
    drive_op(opc, addr, data, gp, 1'b1);
    e.tag = tag;
    e.fault = 1'b0;
    if (ack_at == 0) begin
      e.result = '0; e.chk_res = 1'b1; e.gp_we = 1'b0; e.fault = 1'b1;
    end else if (is_st) begin
      e.result = data; e.chk_res = 1'b1; e.gp_we = 1'b0;
    end else begin
      e.result = rdata; e.chk_res = (flush_at == 0); e.gp_we = (flush_at == 0);
    end
    sb.push_back(e);
    step();
    drive_nop();
    chk({tag, "_req"}, 64'(mem_if.ow_mem_req), 64'd1);
    chk({tag, "_we"}, 64'(mem_if.ow_mem_we), 64'(is_st));
    chk({tag, "_stall"}, 64'(ow_stall_req), 64'd1);
    chk({tag, "_bubble"}, 64'(ow_tgt_gp_we), 64'd0);
    if (is_st) chk({tag, "_wdata"}, 64'(mem_if.ow_mem_wdata), 64'(data));
    reqc = 0;
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (mem_if.ow_mem_req) reqc++;
      chk({tag, "_addr"}, 64'(mem_if.ow_mem_addr), 64'(addr));
      mem_if.iw_mem_ack   = (k == ack_at);
      mem_if.iw_mem_rdata = (k == ack_at) ? rdata : 24'h0;
      iw_flush            = (k == flush_at);
      step();
      mem_if.iw_mem_ack = 1'b0;
      iw_flush          = 1'b0;
      if (!ow_stall_req) done = 1'b1;
    end
    if (!done) chk({tag, "_bound"}, 64'd0, 64'd1);
    chk({tag, "_req_cycles"}, 64'(reqc), 64'(exp_cycles));
    chk({tag, "_req_drop"}, 64'(mem_if.ow_mem_req), 64'd0);
    pop_check();
    step();
    chk({tag, "_fault_after"}, 64'(ow_mem_fault), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iw_rst = 1'b1;
    iw_flush = 1'b0;
    iw_stall = 1'b0;
    mem_if.iw_mem_ack = 1'b0;
    mem_if.iw_mem_rdata = '0;
    drive_nop();
    repeat (3) step();
    chk("rst_result", 64'(ow_result), 64'd0);
    chk("rst_gp_we", 64'(ow_tgt_gp_we), 64'd0);
    chk("rst_sr_we", 64'(ow_tgt_sr_we), 64'd0);
    chk("rst_ar_we", 64'(ow_tgt_ar_we), 64'd0);
    chk("rst_req", 64'(mem_if.ow_mem_req), 64'd0);
    chk("rst_stall", 64'(ow_stall_req), 64'd0);
    chk("rst_fault", 64'(ow_mem_fault), 64'd0);
    iw_rst = 1'b0;

    alu("alu1", 24'h001234, 4'd3, 1'b0);
    mem_op("load", `OPC_LDu, 48'h0000_0000_0400, 24'h0, 4'd5, 3, 24'hABCDEF, 0, 3);
    mem_op("store", `OPC_STu, 48'h0000_0000_0800, 24'h55AA55, 4'd6, 1, 24'h0, 0, 1);
    mem_op("tmo", `OPC_LDs, 48'h0000_0000_0C00, 24'h0, 4'd7, 0, 24'h0, 0, TIMEOUT);
    alu("alu_after_tmo", 24'h00BEEF, 4'd2, 1'b0);
    mem_op("flush_ld", `OPC_LDso, 48'h0000_0000_1000, 24'h0, 4'd9, 4, 24'h123456, 2, 4);
    alu("alu_stray_ack", 24'h00C0DE, 4'd4, 1'b1);

    // Stall in S_IDLE holds the previous write-back fields.
    alu("alu_pre_stall", 24'h000111, 4'd1, 1'b0);
    drive_op(`OPC_ADD, 48'h0, 24'h000222, 4'd8, 1'b1);
    iw_stall = 1'b1;
    step();
    chk("stall_hold_result", 64'(ow_result), 64'h111);
    chk("stall_hold_gp", 64'(ow_tgt_gp), 64'd1);
    iw_stall = 1'b0;
    step();
    chk("stall_release_result", 64'(ow_result), 64'h222);

    // Flush in S_IDLE turns even a load into a bubble with no request.
    drive_op(`OPC_LDu, 48'h0000_0000_2000, 24'h0, 4'd5, 1'b1);
    iw_flush = 1'b1;
    step();
    iw_flush = 1'b0;
    drive_nop();
    chk("idle_flush_gp_we", 64'(ow_tgt_gp_we), 64'd0);
    chk("idle_flush_req", 64'(mem_if.ow_mem_req), 64'd0);
    chk("idle_flush_stall", 64'(ow_stall_req), 64'd0);

    // Reset in the middle of a transaction.
    drive_op(`OPC_STs, 48'h0000_0000_3000, 24'h777777, 4'd3, 1'b1);
    step();
    drive_nop();
    chk("rst_wait_req_pre", 64'(mem_if.ow_mem_req), 64'd1);
    iw_rst = 1'b1;
    step();
    chk("rst_wait_req", 64'(mem_if.ow_mem_req), 64'd0);
    chk("rst_wait_stall", 64'(ow_stall_req), 64'd0);
    chk("rst_wait_gp_we", 64'(ow_tgt_gp_we), 64'd0);
    iw_rst = 1'b0;
    alu("alu_after_rst", 24'h001234, 4'd3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      alu("alu_rand", 24'($urandom), 4'($urandom_range(0, 15)), 1'b0);
    end
    mem_op("load2", `OPC_LDs, 48'h0000_0001_0000, 24'h0, 4'd11, 1, 24'h0F0F0F, 0, 1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stg_ma.md
Name: stg_ma

Overview:
Memory-access stage of the amber pipeline. It sits directly downstream of stg_ex and upstream of write-back.
- Registers execute-stage results.
- For load/store opcodes, runs a variable-latency req/ack transaction on the data-memory port, with a wait-cycle timeout.
- Returns write-back fields one stage later, or inserts bubbles while a transaction is outstanding.
- While waiting it raises a stall request back to IF..EX.

Parameters:
TIMEOUT, 16, wait cycles without iw_mem_ack before the transaction is abandoned (≥1).
TW, 5, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
iw_clk  in  1  clock
iw_rst  in  1  synchronous active-high reset
iw_pc / ow_pc  in/out  `HBIT_ADDR+1  instruction PC, passed through
iw_instr / ow_instr  in/out  `HBIT_DATA+1  instruction word, passed through
iw_opc / ow_opc  in/out  `HBIT_OPC+1  opcode, passed through
iw_tgt_gp / ow_tgt_gp, iw_tgt_gp_we / ow_tgt_gp_we  in/out  `HBIT_TGT_GP+1 / 1  GP target and write enable
iw_tgt_sr / ow_tgt_sr, iw_tgt_sr_we / ow_tgt_sr_we  in/out  `HBIT_TGT_SR+1 / 1  SR target and write enable
iw_tgt_ar / ow_tgt_ar, iw_tgt_ar_we / ow_tgt_ar_we  in/out  `HBIT_TGT_AR+1 / 1  AR target and write enable
iw_addr  in  `HBIT_ADDR+1  effective memory address from EX
iw_result / ow_result  in/out  `HBIT_DATA+1  ALU result; for a load, replaced by the load data
iw_ar_result / ow_ar_result, iw_sr_result / ow_sr_result  in/out  `HBIT_ADDR+1  AR and SR results
ow_mem_req  out  1  memory request
ow_mem_we  out  1  1 = store, 0 = load
ow_mem_addr  out  `HBIT_ADDR+1  memory address
ow_mem_wdata  out  `HBIT_DATA+1  store data
iw_mem_ack  in  1  single-cycle acknowledge; valid only while ow_mem_req=1
iw_mem_rdata  in  `HBIT_DATA+1  load data, valid with the ack
ow_stall_req  out  1  stall request to upstream stages
ow_mem_fault  out  1  one-cycle pulse on timeout
iw_flush  in  1  flush from the branch resolver
iw_stall  in  1  downstream stall

Behaviour:
- Reset (iw_rst sampled high): FSM → S_IDLE; timeout counter = 0; every ow_* = 0, including all *_we, ow_mem_req and ow_stall_req. Reset overrides any outstanding transaction; the memory side must tolerate a dropped req.
- Opcode classes, from src/opcodes.vh:
  - load class = every OPC_LD* opcode;
  - store class = every OPC_ST*;
  - every other opcode is non-memory.
- S_IDLE, iw_stall=1: all state and outputs hold.
- S_IDLE, iw_flush=1: capture a bubble. All *_we = 0; other fields don't-care, driven 0. No memory op starts.
- S_IDLE, non-memory op: all iw_* fields are registered to ow_* at the next edge. Latency 1.
- S_IDLE, memory op: at the edge, capture all fields into a hold register and go to S_WAIT.
  - Set ow_mem_req=1, ow_mem_addr=iw_addr, ow_mem_we=store.
  - For a store, ow_mem_wdata=iw_result.
  - All ow_*_we = 0 (bubble); ow_stall_req=1; counter = 0.
- S_WAIT: ow_mem_req, ow_mem_addr, ow_mem_we and ow_mem_wdata held stable; ow_stall_req=1. iw_stall and iw_flush are not sampled, except as recorded in the flush bullet below.
  - Ack sampled: ow_mem_req=0, ow_stall_req=0, back to S_IDLE. Register the hold fields to ow_*.
    - Load: ow_result = iw_mem_rdata.
    - Store: ow_result = held result; all *_we forced 0.
  - No ack and counter == TIMEOUT-1: drop ow_mem_req; ow_mem_fault=1 for exactly one cycle; writeback suppressed (all *_we = 0); back to S_IDLE.
  - Otherwise counter increments.
- Earliest completion: instruction at MA input in cycle N → req visible N+1. Ack in N+1 → write-back fields valid N+2 and stall released N+2.
- Flush while in S_WAIT: recorded in a sticky bit. The transaction still runs to ack or timeout; a store still writes memory. On completion the writeback is suppressed (all *_we = 0). The sticky bit clears on return to S_IDLE.
- Ack while ow_mem_req=0: ignored.
- ow_mem_fault: 0 in every cycle except the timeout pulse.

Test Plan:
1. Reset, then a non-memory op: iw_result=24'h00_1234, tgt_gp=3, we=1 → next cycle ow_result=24'h001234, ow_tgt_gp=3, ow_tgt_gp_we=1, ow_mem_req=0.
2. Load: iw_addr=48'h0000_0000_0400, tgt_gp=5; memory acks 3 cycles after req with rdata=24'hABCDEF.
   - ow_mem_req=1, ow_mem_we=0, ow_stall_req=1 for 3 cycles.
   - Next cycle ow_result=24'hABCDEF, ow_tgt_gp_we=1.
3. Store: iw_addr=48'h0000_0000_0800, iw_result=24'h55AA55; ack in the first req cycle → ow_mem_we=1, ow_mem_wdata=24'h55AA55, ow_stall_req high for exactly 1 cycle, no *_we asserted.
4. Load with no ack, TIMEOUT=16 → req high 16 cycles, ow_mem_fault single pulse, *_we=0, S_IDLE; a following non-memory op completes normally.
5. Load, iw_flush=1 during the 2nd wait cycle, ack at the 4th → rdata not written (ow_tgt_gp_we=0); stall released after the ack.
6. Reset asserted during S_WAIT → next cycle ow_mem_req=0, ow_stall_req=0, all *_we=0; a subsequent op behaves as in scenario 1.
